inst_encoder_loader: RTL

Encodes decoded instruction fields into 32-bit MIPS instruction words and writes them in order into instruction memory. It is the encoding counterpart of the control-unit opcode decoder, and it loads test and boot programs. It accepts only the opcode set the datapath decodes and rejects everything else. It sits between a program-source master (bench or host link) and the instruction-memory write port.

---
 rtl/inst_encoder_loader_if.sv | 31 +++
 rtl/inst_encoder_loader.sv | 113 +++++++++++
 2 files changed

// File: rtl/inst_encoder_loader_if.sv
// Program-source beat channel and instruction-memory write port of the encoder/loader.
// The master is the program source; the slave is the loader itself.
interface inst_encoder_loader_if #(parameter int ADDR_W = 8);
    logic              start;
    logic [ADDR_W-1:0] baseAddr;
    logic              inValid;
    logic              inReady;
    logic [1:0]        fmt;
    logic [5:0]        op;
    logic [4:0]        rs;
    logic [4:0]        rt;
    logic [4:0]        rd;
    logic [4:0]        shamt;
    logic [5:0]        funct;
    logic [15:0]       imm;
    logic [25:0]       target;
    logic              last;
    logic              memWe;
    logic [ADDR_W-1:0] memAddr;
    logic [31:0]       memWdata;

    modport master (
        output start, baseAddr, inValid, fmt, op, rs, rt, rd, shamt, funct, imm, target, last,
        input  inReady, memWe, memAddr, memWdata
    );

    modport slave (
        input  start, baseAddr, inValid, fmt, op, rs, rt, rd, shamt, funct, imm, target, last,
        output inReady, memWe, memAddr, memWdata
    );
endinterface

// File: rtl/inst_encoder_loader.sv
// Encodes R/I/J instruction fields into MIPS words and writes them sequentially
// into instruction memory, rejecting opcodes the datapath cannot decode.
//
// state  | meaning
// IDLE   | no session, waiting for start
// ACCEPT | ready for the next field beat
// WRITE  | one-cycle memory write of the latched word
// DONE   | last word written, sticky until start
// ERROR  | session aborted, errCode holds the reason
module inst_encoder_loader #(
    parameter int ADDR_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    inst_encoder_loader_if.slave bus,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [1:0]           errCode,
    output logic [ADDR_W:0]      count
);
    typedef enum logic [2:0] {IDLE, ACCEPT, WRITE, DONE, ERROR} stateT;

    stateT             state;
    stateT             stateNext;
    logic [ADDR_W-1:0] ptr;
    logic              lastReg;
    logic              opR;
    logic              opI;
    logic              opJ;
    logic              fmtMatch;
    logic [1:0]        rejectCode;
    logic              handshake;
    logic [31:0]       encoded;

    assign opR = (bus.op == 6'd0);
    assign opJ = (bus.op == 6'd2);
    assign opI = (bus.op inside {6'd4, 6'd8, 6'd9, 6'd10, 6'd12, 6'd13, 6'd14, 6'd35, 6'd43});
    assign fmtMatch = (opR && bus.fmt == 2'd0) || (opI && bus.fmt == 2'd1) || (opJ && bus.fmt == 2'd2);
    assign rejectCode = !(opR || opI || opJ) ? 2'd1 : (fmtMatch ? 2'd0 : 2'd2);
    assign handshake = (state == ACCEPT) && bus.inValid && !bus.start;

    // Write strobe is decoded from state so an async reset removes it at once.
    assign bus.inReady = (state == ACCEPT) && !bus.start;
    assign bus.memWe   = (state == WRITE);
    assign busy        = (state == ACCEPT) || (state == WRITE);
    assign done        = (state == DONE);
    assign err         = (state == ERROR);

    always_comb begin
        encoded = 32'd0;
        unique case (bus.fmt)
            2'd0:    encoded = {bus.op, bus.rs, bus.rt, bus.rd, bus.shamt, bus.funct};
            2'd1:    encoded = {bus.op, bus.rs, bus.rt, bus.imm};
            2'd2:    encoded = {bus.op, bus.target};
            default: encoded = 32'd0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        unique case (state)
            IDLE: stateNext = IDLE;
            ACCEPT: begin
                if (handshake) stateNext = (rejectCode == 2'd0) ? WRITE : ERROR;
            end
            WRITE: begin
                if (lastReg)          stateNext = DONE;
                else if (ptr == '1)   stateNext = ERROR;
                else                  stateNext = ACCEPT;
            end
            DONE:    stateNext = DONE;
            ERROR:   stateNext = ERROR;
            default: stateNext = IDLE;
        endcase
        if (bus.start) stateNext = ACCEPT;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr          <= '0;
            lastReg      <= 1'b0;
            count        <= '0;
            errCode      <= 2'd0;
            bus.memAddr  <= '0;
            bus.memWdata <= 32'd0;
        end else if (bus.start) begin
            ptr     <= bus.baseAddr;
            count   <= '0;
            errCode <= 2'd0;
        end else if (handshake) begin
            if (rejectCode != 2'd0) begin
                errCode <= rejectCode;
            end else begin
                bus.memAddr  <= ptr;
                bus.memWdata <= encoded;
                lastReg      <= bus.last;
            end
        end else if (state == WRITE) begin
            count <= count + (ADDR_W + 1)'(1);
            if (!lastReg) begin
                // The top word is still written; the pointer never wraps.
                if (ptr == '1) errCode <= 2'd3;
                else           ptr     <= ptr + ADDR_W'(1);
            end
        end
    end
endmodule
